// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush sequencer for load-use, EX redirect and memory wait hazards
// Optional forced release of long memory waits: define HAZ_MEM_TIMEOUT_EN.
module pipeline_hazard_ctrl #(
    parameter int CNT_W = 32
`ifdef HAZ_MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       ID_rs1,
    input  logic [4:0]       ID_rs2,
    input  logic             ID_use_rs1,
    input  logic             ID_use_rs2,
    input  logic             EX_MemRead,
    input  logic [4:0]       EX_rd,
    input  logic             EX_redirect,
    input  logic             MEM_req,
    input  logic             MEM_ack,
    output logic             PC_Pause,
    output logic             IFID_Pause,
    output logic             IFID_Flush,
    output logic             IDEX_Pause,
    output logic             IDEX_Flush,
    output logic             EXMEM_Pause,
    output logic             MEMWB_Flush,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] rd_cnt,
    output logic [CNT_W-1:0] mw_cnt,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1
    } state_t;

    state_t state;
    logic   lu_hit;
    logic   mem_ack_eff;
    logic   mem_wait;
    logic   redirect;
    logic   load_use;

`ifdef HAZ_MEM_TIMEOUT_EN
    localparam int WAIT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    logic [WAIT_W-1:0] wait_cnt;
    logic              timeout_hit;
    logic              mem_err_r;

    // A timeout is indistinguishable from an ack for the pipeline; only mem_err records it.
    assign timeout_hit = (state == MEM_WAIT) && (wait_cnt == WAIT_W'(TIMEOUT));
    assign mem_ack_eff = MEM_ack | timeout_hit;
    assign mem_err     = mem_err_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt  <= '0;
            mem_err_r <= 1'b0;
        end else begin
            if (mem_wait)
                wait_cnt <= (state == RUN) ? WAIT_W'(1) : wait_cnt + WAIT_W'(1);
            if (timeout_hit && !MEM_ack)
                mem_err_r <= 1'b1;
        end
    end
`else
    assign mem_ack_eff = MEM_ack;
    assign mem_err     = 1'b0;
`endif

    assign lu_hit = EX_MemRead && (EX_rd != 5'd0) &&
                    ((ID_use_rs1 && (ID_rs1 == EX_rd)) || (ID_use_rs2 && (ID_rs2 == EX_rd)));

    // The ack cycle of a wait behaves as RUN so redirect/load-use seen then are honoured.
    assign mem_wait = !rst && (((state == RUN) && MEM_req && !MEM_ack) ||
                               ((state == MEM_WAIT) && !mem_ack_eff));
    assign redirect = !rst && !mem_wait && EX_redirect;
    assign load_use = !rst && !mem_wait && !EX_redirect && lu_hit;

    assign PC_Pause    = mem_wait || load_use;
    assign IFID_Pause  = mem_wait || load_use;
    assign IFID_Flush  = redirect;
    assign IDEX_Pause  = mem_wait;
    assign IDEX_Flush  = redirect || load_use;
    assign EXMEM_Pause = mem_wait;
    assign MEMWB_Flush = mem_wait;
    assign state_o     = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            lu_cnt <= '0;
            rd_cnt <= '0;
            mw_cnt <= '0;
        end else begin
            state <= mem_wait ? MEM_WAIT : RUN;
            if (load_use)
                lu_cnt <= lu_cnt + CNT_W'(1);
            if (redirect)
                rd_cnt <= rd_cnt + CNT_W'(1);
            if (mem_wait)
                mw_cnt <= mw_cnt + CNT_W'(1);
        end
    end

endmodule
